lms_train_ctrl: RTL and testbench
=================================

Name: lms_train_ctrl

Overview:
Training sequencer for the 16-tap DA-based LMS adaptive filter.
- Gates the sample stream into the filter through a valid/ready handshake.
- Withholds adaptation until the tap delay line has filled.
- Enables weight updates and anneals the step size (error right-shift) as the windowed mean |error| falls.
- Declares convergence, tracks for divergence, and flags a training timeout.

Parameters:
TAPS, 16, filter length; samples accepted in FILL before adaptation starts
WIN_LOG2, 5, log2 of the error-averaging window in error samples (window = 32)
CONV_THR, 64, windowed mean |err| below this counts as a converged window
DIV_THR, 512, windowed mean |err| above this in TRACK is divergence
CONV_WINS, 2, consecutive converged windows required to enter TRACK
MAX_TRAIN, 4096, accepted samples allowed in TRAIN before FAIL
MU_INIT, 4, initial error right-shift (step size)
MU_MAX, 7, largest right-shift (smallest step)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
start  in  1  pulse: begin a training run
abort  in  1  pulse: return to IDLE
s_valid  in  1  upstream sample (xin/din) valid
s_ready  out  1  controller accepts sample; the filter advances on s_valid&s_ready
adapt_en  out  1  weight-update enable for the accepted sample (combinational: s_valid&s_ready&state∈{TRAIN,TRACK})
err  in  12  signed filter error din−filt_out
err_vld  in  1  err is valid this cycle (datapath-aligned to an accepted sample)
mu_shift  out  3  error right-shift fed to the sign-magnitude/control-word path
state_o  out  3  current state encoding
converged  out  1  high while in TRACK
fail  out  1  high while in FAIL
avg_err  out  12  last completed window mean |err|

Behaviour:
- Reset: state IDLE, s_ready=0, mu_shift=MU_INIT, converged=0, fail=0, avg_err=0, all counters 0.
- State encodings: IDLE=0, FILL=1, TRAIN=2, TRACK=3, FAIL=4.
- Priority each cycle: rst > abort > start > normal transitions. abort in any state → IDLE next cycle; counters clear and mu_shift resets to MU_INIT. start while not IDLE/FAIL is ignored.
- IDLE: s_ready=0. start → FILL; clears fill_cnt, train_cnt, win_cnt, acc, conv_cnt; mu_shift=MU_INIT.
- FILL: s_ready=1, adapt_en=0, err_vld ignored. fill_cnt increments per handshake. The handshake that makes fill_cnt==TAPS moves the block to TRAIN on the next edge.
- TRAIN: s_ready=1. train_cnt increments per handshake.
  - On err_vld: |err| accumulates into acc (width 12+WIN_LOG2); −2048 saturates to 2047; win_cnt increments.
  - Window end (win_cnt reaches 2^WIN_LOG2, including the current sample): avg_err = acc>>WIN_LOG2; acc and win_cnt clear.
  - If avg_err<CONV_THR: conv_cnt++ and mu_shift=min(mu_shift+1, MU_MAX). Otherwise conv_cnt=0 and mu_shift is unchanged.
  - When conv_cnt reaches CONV_WINS → TRACK.
  - train_cnt==MAX_TRAIN with no transition → FAIL.
  - If a window end and the MAX_TRAIN limit fall on the same cycle, the convergence evaluation wins.
- TRACK: s_ready=1, converged=1, mu_shift is held. Windows are still evaluated.
  - avg_err>DIV_THR → TRAIN, with mu_shift=MU_INIT, conv_cnt=0, train_cnt=0.
- FAIL: s_ready=0, fail=1. start → FILL, with the same clears as IDLE→FILL.
- Latency: state change is registered, one cycle after the deciding handshake or window end. adapt_en tracks the handshake combinationally in the same cycle.
- s_ready does not depend on s_valid (no combinational loop).
- err_vld arriving while in IDLE or FILL is dropped and does not touch acc.

Decomposition:
- Shared package: state enum (3 bits), ERR_W=12, X_W=8, MU_W=3, saturating-abs function.
- One sub-module, err_window_avg: abs, accumulate, window counter, mean output and window_done pulse. The FSM and counters remain in lms_train_ctrl.

Test Plan:
- Reset then idle: rst 2 cycles, s_valid=1 → s_ready=0, mu_shift=4, state_o=0, adapt_en never high.
- Fill gating: start, 16 handshakes with s_valid=1 → adapt_en=0 for all 16, state_o=2 the cycle after the 16th, adapt_en=1 on the 17th handshake.
- Convergence anneal: in TRAIN, feed err=±10 with err_vld for 64 samples → avg_err=10, mu_shift 4→5 after window 1 and 5→6 after window 2, converged=1.
- Divergence: in TRACK, 32 samples of err=−2048 → avg_err=2047, state TRAIN, mu_shift=4, converged=0.
- Timeout: TRAIN with err=300 constant for 4096 handshakes → fail=1, s_ready=0; a later start → FILL.
- Abort priority: start and abort in the same cycle from IDLE → stays IDLE. Abort mid-TRAIN with acc nonzero → IDLE next cycle, mu_shift=4, and a fresh run starts with empty counters.

Source files
------------

// File: rtl/lms_train_ctrl_pkg.sv
// Shared types and helpers for the LMS training sequencer: state encoding,
// datapath widths and a saturating absolute value for the filter error.
package lms_train_ctrl_pkg;

    localparam int ERR_W = 12;
    localparam int X_W   = 8;
    localparam int MU_W  = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_TRAIN = 3'd2,
        ST_TRACK = 3'd3,
        ST_FAIL  = 3'd4
    } state_t;

    // -2048 has no positive twin in 12 bits, so it clamps to 2047.
    function automatic logic [ERR_W-1:0] sat_abs(input logic signed [ERR_W-1:0] v);
        if (v == {1'b1, {(ERR_W-1){1'b0}}})
            return {1'b0, {(ERR_W-1){1'b1}}};
        else if (v[ERR_W-1])
            return ERR_W'(-v);
        else
            return v;
    endfunction

endpackage

// File: rtl/lms_train_ctrl_err_window_avg.sv
// Windowed mean |err|: accumulates 2^WIN_LOG2 error magnitudes; done/mean are combinational
// on the closing sample, avg is registered at that edge. No backpressure (err is never stalled).
module lms_train_ctrl_err_window_avg
    import lms_train_ctrl_pkg::*;
#(
    parameter int WIN_LOG2 = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_clr,
    input  logic                    i_en,
    input  logic signed [ERR_W-1:0] i_err,
    output logic                    o_win_done,
    output logic [ERR_W-1:0]        o_win_mean,
    output logic [ERR_W-1:0]        o_avg_err
);

    localparam int ACC_W = ERR_W + WIN_LOG2;

    logic [ACC_W-1:0]    r_acc;
    logic [WIN_LOG2-1:0] r_win_cnt;
    logic [ERR_W-1:0]    r_avg_err;
    logic [ERR_W-1:0]    w_abs;
    logic [ACC_W-1:0]    w_sum;

    assign w_abs      = sat_abs(i_err);
    assign w_sum      = r_acc + ACC_W'(w_abs);
    // Counter holding all-ones means the current sample closes the window.
    assign o_win_done = i_en && (r_win_cnt == '1);
    assign o_win_mean = w_sum[ACC_W-1:WIN_LOG2];
    assign o_avg_err  = r_avg_err;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_acc     <= '0;
            r_win_cnt <= '0;
        end else if (i_en) begin
            r_acc     <= o_win_done ? '0 : w_sum;
            r_win_cnt <= r_win_cnt + WIN_LOG2'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_avg_err <= '0;
        else if (!i_clr && o_win_done)
            r_avg_err <= o_win_mean;
    end

endmodule

// File: rtl/lms_train_ctrl.sv
// Training sequencer for the DA LMS filter: fill gating, step-size anneal, convergence/divergence/timeout.
// State changes one cycle after the deciding handshake; s_ready is state-only, adapt_en follows the handshake.
module lms_train_ctrl
    import lms_train_ctrl_pkg::*;
#(
    parameter int TAPS      = 16,
    parameter int WIN_LOG2  = 5,
    parameter int CONV_THR  = 64,
    parameter int DIV_THR   = 512,
    parameter int CONV_WINS = 2,
    parameter int MAX_TRAIN = 4096,
    parameter int MU_INIT   = 4,
    parameter int MU_MAX    = 7
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    s_valid,
    output logic                    s_ready,
    output logic                    adapt_en,
    input  logic signed [ERR_W-1:0] err,
    input  logic                    err_vld,
    output logic [MU_W-1:0]         mu_shift,
    output logic [2:0]              state_o,
    output logic                    converged,
    output logic                    fail,
    output logic [ERR_W-1:0]        avg_err
);

    localparam int FILL_W  = $clog2(TAPS + 1);
    localparam int TRAIN_W = $clog2(MAX_TRAIN + 1);
    localparam int CONV_W  = $clog2(CONV_WINS + 1);

    state_t             r_state, w_state_nxt;
    logic [FILL_W-1:0]  r_fill_cnt, w_fill_nxt;
    logic [TRAIN_W-1:0] r_train_cnt, w_train_nxt;
    logic [CONV_W-1:0]  r_conv_cnt, w_conv_nxt;
    logic [MU_W-1:0]    r_mu, w_mu_nxt;

    logic             w_hs;
    logic             w_adapting;
    logic             w_restart;
    logic             w_clr;
    logic             w_win_done;
    logic [ERR_W-1:0] w_win_mean;

    assign s_ready    = (r_state == ST_FILL) || (r_state == ST_TRAIN) || (r_state == ST_TRACK);
    assign w_adapting = (r_state == ST_TRAIN) || (r_state == ST_TRACK);
    assign w_hs       = s_valid && s_ready;
    assign adapt_en   = w_hs && w_adapting;
    assign w_restart  = start && ((r_state == ST_IDLE) || (r_state == ST_FAIL));
    assign w_clr      = abort || w_restart;

    assign mu_shift   = r_mu;
    assign state_o    = r_state;
    assign converged  = (r_state == ST_TRACK);
    assign fail       = (r_state == ST_FAIL);

    lms_train_ctrl_err_window_avg #(
        .WIN_LOG2 (WIN_LOG2)
    ) u_win (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (w_clr),
        .i_en       (err_vld && w_adapting),
        .i_err      (err),
        .o_win_done (w_win_done),
        .o_win_mean (w_win_mean),
        .o_avg_err  (avg_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_fill_cnt  <= '0;
            r_train_cnt <= '0;
            r_conv_cnt  <= '0;
            r_mu        <= MU_W'(MU_INIT);
        end else begin
            r_state     <= w_state_nxt;
            r_fill_cnt  <= w_fill_nxt;
            r_train_cnt <= w_train_nxt;
            r_conv_cnt  <= w_conv_nxt;
            r_mu        <= w_mu_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_fill_nxt  = r_fill_cnt;
        w_train_nxt = r_train_cnt;
        w_conv_nxt  = r_conv_cnt;
        w_mu_nxt    = r_mu;

        if (abort) begin
            w_state_nxt = ST_IDLE;
            w_fill_nxt  = '0;
            w_train_nxt = '0;
            w_conv_nxt  = '0;
            w_mu_nxt    = MU_W'(MU_INIT);
        end else if (w_restart) begin
            w_state_nxt = ST_FILL;
            w_fill_nxt  = '0;
            w_train_nxt = '0;
            w_conv_nxt  = '0;
            w_mu_nxt    = MU_W'(MU_INIT);
        end else begin
            case (r_state)
                ST_FILL: begin
                    if (w_hs) begin
                        w_fill_nxt = r_fill_cnt + FILL_W'(1);
                        if (r_fill_cnt == FILL_W'(TAPS - 1))
                            w_state_nxt = ST_TRAIN;
                    end
                end
                ST_TRAIN: begin
                    if (w_hs)
                        w_train_nxt = r_train_cnt + TRAIN_W'(1);
                    if (w_win_done) begin
                        if (w_win_mean < ERR_W'(CONV_THR)) begin
                            w_conv_nxt = r_conv_cnt + CONV_W'(1);
                            w_mu_nxt   = (r_mu >= MU_W'(MU_MAX)) ? MU_W'(MU_MAX) : r_mu + MU_W'(1);
                            if (r_conv_cnt == CONV_W'(CONV_WINS - 1))
                                w_state_nxt = ST_TRACK;
                        end else begin
                            w_conv_nxt = '0;
                        end
                    end
                    // A convergence exit on the same cycle beats the timeout.
                    if (w_state_nxt == ST_TRAIN && w_hs && r_train_cnt == TRAIN_W'(MAX_TRAIN - 1))
                        w_state_nxt = ST_FAIL;
                end
                ST_TRACK: begin
                    if (w_win_done && w_win_mean > ERR_W'(DIV_THR)) begin
                        w_state_nxt = ST_TRAIN;
                        w_mu_nxt    = MU_W'(MU_INIT);
                        w_conv_nxt  = '0;
                        w_train_nxt = '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lms_train_ctrl.sv
// Directed-plus-random bench for lms_train_ctrl against a cycle-level reference of the training rules.
module tb_lms_train_ctrl;

    logic              clk = 1'b0;
    logic              rst, start, abort, s_valid, err_vld;
    logic signed [11:0] err;
    logic              s_ready, adapt_en, converged, fail;
    logic [2:0]        mu_shift, state_o;
    logic [11:0]       avg_err;

    int n_cmp  = 0;
    int n_fail = 0;
    logic last_adapt;

    // reference model: plain counters following the training rules
    int m_st, m_fill, m_train, m_wsum, m_wn, m_mu, m_conv, m_avg;

    lms_train_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .adapt_en  (adapt_en),
        .err       (err),
        .err_vld   (err_vld),
        .mu_shift  (mu_shift),
        .state_o   (state_o),
        .converged (converged),
        .fail      (fail),
        .avg_err   (avg_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit m_ready();
        return (m_st >= 1 && m_st <= 3);
    endfunction

    task automatic m_clear_run();
        m_fill = 0; m_train = 0; m_wsum = 0; m_wn = 0; m_conv = 0;
    endtask

    task automatic m_reset();
        m_st = 0; m_clear_run(); m_mu = 4; m_avg = 0;
    endtask

    task automatic m_edge(input bit st, input bit ab, input bit sv, input bit ev, input int e);
        int  a;
        int  nx;
        bit  hs;
        bit  done;
        hs = sv && m_ready();
        if (ab) begin
            m_st = 0; m_clear_run(); m_mu = 4;
            return;
        end
        if (st && (m_st == 0 || m_st == 4)) begin
            m_st = 1; m_clear_run(); m_mu = 4;
            return;
        end
        if (m_st == 1) begin
            if (hs) begin
                m_fill++;
                if (m_fill == 16) m_st = 2;
            end
        end else if (m_st == 2 || m_st == 3) begin
            nx = m_st;
            done = 0;
            if (m_st == 2 && hs) m_train++;
            if (ev) begin
                a = (e < 0) ? -e : e;
                if (a > 2047) a = 2047;
                m_wsum += a;
                m_wn++;
                if (m_wn == 32) begin
                    m_avg = m_wsum / 32; m_wsum = 0; m_wn = 0; done = 1;
                end
            end
            if (done && m_st == 2) begin
                if (m_avg < 64) begin
                    m_conv++;
                    m_mu = (m_mu < 7) ? m_mu + 1 : 7;
                    if (m_conv >= 2) nx = 3;
                end else begin
                    m_conv = 0;
                end
            end
            if (done && m_st == 3 && m_avg > 512) begin
                nx = 2; m_mu = 4; m_conv = 0; m_train = 0;
            end
            if (m_st == 2 && nx == 2 && m_train == 4096) nx = 4;
            m_st = nx;
        end
    endtask

    // One clock: drive, check combinational outputs, advance model, check registered outputs.
    task automatic cyc(input bit sv, input bit ev, input int e, input bit st, input bit ab);
        logic [20:0] exp_regs;
        s_valid = sv; err_vld = ev; err = 12'(e); start = st; abort = ab;
        #1;
        last_adapt = adapt_en;
        chk("s_ready", 32'(s_ready), 32'(m_ready()));
        chk("adapt_en", 32'(adapt_en), 32'(sv && m_ready() && (m_st == 2 || m_st == 3)));
        m_edge(st, ab, sv, ev, e);
        @(posedge clk);
        #1;
        exp_regs = {m_st[2:0], m_mu[2:0], (m_st == 3), (m_st == 4), m_avg[11:0]};
        chk("regs", 32'({state_o, mu_shift, converged, fail, avg_err}), 32'(exp_regs));
        start = 1'b0; abort = 1'b0;
    endtask

    task automatic fill16();
        cyc(0, 0, 0, 1, 0);
        for (int i = 0; i < 16; i++)
            cyc(1, 1, int'($urandom_range(0, 4095)) - 2048, 0, 0);
    endtask

    initial begin
        int k;
        rst = 1'b1; start = 1'b0; abort = 1'b0; s_valid = 1'b1; err_vld = 1'b0; err = '0;
        last_adapt = 1'b0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", 32'(state_o), 0);
        chk("rst_mu", 32'(mu_shift), 4);
        chk("rst_ready", 32'(s_ready), 0);
        chk("rst_adapt", 32'(adapt_en), 0);
        chk("rst_avg", 32'(avg_err), 0);
        chk("rst_flags", 32'({converged, fail}), 0);
        rst = 1'b0;

        repeat (3) cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 1, 1);
        chk("start_abort_idle", 32'(state_o), 0);

        // fill gating: err_vld during FILL must be dropped
        cyc(0, 0, 0, 1, 0);
        chk("start_fill", 32'(state_o), 1);
        for (int i = 0; i < 16; i++)
            cyc(1, 1, int'($urandom_range(0, 4095)) - 2048, 0, 0);
        chk("fill_to_train", 32'(state_o), 2);

        // convergence anneal with random bubbles
        k = 0;
        while (k < 64) begin
            if ($urandom_range(0, 3) == 0)
                cyc(0, 0, 0, 0, 0);
            else begin
                cyc(1, 1, ($urandom_range(0, 1) != 0) ? 10 : -10, 0, 0);
                k++;
                if (k == 1)  chk("adapt_17th", 32'(last_adapt), 1);
                if (k == 32) chk("mu_win1", 32'(mu_shift), 5);
            end
        end
        chk("conv_avg", 32'(avg_err), 10);
        chk("conv_mu", 32'(mu_shift), 6);
        chk("conv_flag", 32'(converged), 1);

        // tracking with small noise; start must be ignored
        for (int i = 0; i < 40; i++)
            cyc($urandom_range(0, 3) != 0, 1, int'($urandom_range(0, 126)) - 63, 0, 0);
        cyc(1, 1, 5, 1, 0);
        chk("start_ignored", 32'(state_o), 3);
        while (m_wn != 0) cyc(1, 1, 3, 0, 0);
        chk("track_hold_mu", 32'(mu_shift), 6);

        // divergence
        for (int i = 0; i < 32; i++) cyc(1, 1, -2048, 0, 0);
        chk("div_avg", 32'(avg_err), 2047);
        chk("div_state", 32'(state_o), 2);
        chk("div_mu", 32'(mu_shift), 4);
        chk("div_conv", 32'(converged), 0);

        // random non-converging training, then abort with a partial window
        for (int i = 0; i < 150; i++)
            cyc($urandom_range(0, 4) != 0, $urandom_range(0, 5) != 0,
                int'($urandom_range(0, 2000)) - 1000, 0, 0);
        for (int i = 0; i < 5; i++) cyc(1, 1, 1000, 0, 0);
        cyc(0, 0, 0, 0, 1);
        chk("abort_state", 32'(state_o), 0);
        chk("abort_mu", 32'(mu_shift), 4);
        fill16();
        for (int i = 0; i < 32; i++) cyc(1, 1, ($urandom_range(0, 1) != 0) ? 20 : -20, 0, 0);
        chk("fresh_avg", 32'(avg_err), 20);
        chk("fresh_mu", 32'(mu_shift), 5);
        chk("fresh_state", 32'(state_o), 2);

        // timeout
        cyc(0, 0, 0, 0, 1);
        fill16();
        for (int i = 0; i < 4096; i++) begin
            cyc(1, 1, 300, 0, 0);
            if (i == 4094) chk("pre_timeout", 32'(state_o), 2);
        end
        chk("timeout_fail", 32'(fail), 1);
        chk("timeout_ready", 32'(s_ready), 0);
        chk("timeout_avg", 32'(avg_err), 300);
        cyc(1, 0, 0, 1, 0);
        chk("fail_restart", 32'(state_o), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
